// File: rtl/psw_stack_if.sv
// Handshake bundle for psw_stack: retire/trap/rfi/mt requests in, live PSW and stack status out.
// ncount and NCNT_W exist only when PSW_NCOUNT_EN is defined.
interface psw_stack_if #(
   parameter int CB_W  = 8,
   parameter int DEPTH = 4
`ifdef PSW_NCOUNT_EN
   ,
   parameter int NCNT_W = 16
`endif
);
   logic                       psw_en;
   logic [CB_W-1:0]            cb_in;
   logic                       v_in;
   logic                       n_in;
   logic                       trap;
   logic                       rfi;
   logic                       mt_we;
   logic [CB_W+1:0]            mt_data;
   logic [CB_W-1:0]            cb_out;
   logic                       v_out;
   logic                       n_out;
   logic [CB_W+1:0]            psw_out;
   logic [$clog2(DEPTH):0]     depth_out;
   logic                       stk_err;
`ifdef PSW_NCOUNT_EN
   logic [NCNT_W-1:0]          ncount;
`endif

   modport master (
      output psw_en, cb_in, v_in, n_in, trap, rfi, mt_we, mt_data,
      input  cb_out, v_out, n_out, psw_out, depth_out, stk_err
`ifdef PSW_NCOUNT_EN
      , input ncount
`endif
   );

   modport slave (
      input  psw_en, cb_in, v_in, n_in, trap, rfi, mt_we, mt_data,
      output cb_out, v_out, n_out, psw_out, depth_out, stk_err
`ifdef PSW_NCOUNT_EN
      , output ncount
`endif
   );
endinterface

// File: rtl/psw_stack.sv
// PA-RISC processor status word {n,v,cb} with a LIFO of saved PSWs for nested traps.
// Optional nullified-retire counter enabled by defining PSW_NCOUNT_EN.
module psw_stack #(
   parameter int CB_W   = 8,
   parameter int DEPTH  = 4,
   parameter int NCNT_W = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   psw_stack_if.slave bus
);
   localparam int PW = CB_W + 2;
   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;
   localparam logic [DW-1:0] FULL = DW'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || NCNT_W < 1) begin : g_bad_param
      $error("psw_stack: DEPTH must be a power of two >= 2 and NCNT_W >= 1");
   end

   logic [PW-1:0] psw_q, psw_d;
   logic [DW-1:0] depth_q, depth_d;
   logic          err_q, err_d;
   logic          push;
   logic [AW-1:0] top_idx;
   logic [PW-1:0] stack_q [DEPTH];

   assign top_idx = AW'(depth_q - 1'b1);

   // Request priority: trap > rfi > mt_we > psw_en; losers are simply dropped.
   always_comb begin
      psw_d   = psw_q;
      depth_d = depth_q;
      err_d   = err_q;
      push    = 1'b0;
      if (bus.trap) begin
         if (depth_q == FULL) begin
            err_d = 1'b1;
         end else begin
            push    = 1'b1;
            depth_d = depth_q + 1'b1;
         end
         psw_d = '0;
      end else if (bus.rfi) begin
         if (depth_q == '0) begin
            psw_d = '0;
            err_d = 1'b1;
         end else begin
            psw_d   = stack_q[top_idx];
            depth_d = depth_q - 1'b1;
         end
      end else if (bus.mt_we) begin
         psw_d = bus.mt_data;
         if (bus.mt_data == '0) err_d = 1'b0;
      end else if (bus.psw_en) begin
         if (psw_q[PW-1]) begin
            psw_d[PW-1] = 1'b0;
         end else begin
            psw_d = {bus.n_in, bus.v_in, bus.cb_in};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psw_q   <= '0;
         depth_q <= '0;
         err_q   <= 1'b0;
      end else begin
         psw_q   <= psw_d;
         depth_q <= depth_d;
         err_q   <= err_d;
      end
   end

   // A push always lands in the slot just above the current top.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            stack_q[gi] <= '0;
         end else if (push && depth_q[AW-1:0] == AW'(gi)) begin
            stack_q[gi] <= psw_q;
         end
      end
   end

`ifdef PSW_NCOUNT_EN
   logic [NCNT_W-1:0] ncount_q, ncount_d;
   logic              nullify;

   assign nullify = bus.psw_en & psw_q[PW-1] & ~bus.trap & ~bus.rfi & ~bus.mt_we;

   always_comb begin
      ncount_d = ncount_q;
      if (nullify && ncount_q != '1) ncount_d = ncount_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ncount_q <= '0;
      else        ncount_q <= ncount_d;
   end

   assign bus.ncount = ncount_q;
`endif

   assign bus.cb_out    = psw_q[CB_W-1:0];
   assign bus.v_out     = psw_q[CB_W];
   assign bus.n_out     = psw_q[PW-1];
   assign bus.psw_out   = psw_q;
   assign bus.depth_out = depth_q;
   assign bus.stk_err   = err_q;
endmodule

// File: tb/tb_psw_stack.sv
// Directed bench for psw_stack: queue-based PSW model checked every cycle plus literal expectations.
module tb_psw_stack;
   localparam int CB_W   = 8;
   localparam int DEPTH  = 4;
   localparam int NCNT_W = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   psw_stack_if #(.CB_W(CB_W), .DEPTH(DEPTH)
`ifdef PSW_NCOUNT_EN
      , .NCNT_W(NCNT_W)
`endif
   ) bus ();

   psw_stack #(.CB_W(CB_W), .DEPTH(DEPTH), .NCNT_W(NCNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [7:0] m_cb  = '0;
   logic       m_v   = 1'b0;
   logic       m_n   = 1'b0;
   logic       m_err = 1'b0;
   logic [9:0] m_stk [$];
   int         m_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_cb = '0; m_v = 1'b0; m_n = 1'b0; m_err = 1'b0; m_cnt = 0;
      m_stk.delete();
   endtask

   task automatic model_step(input logic t, input logic r, input logic w, input logic e,
                             input logic [9:0] md, input logic [7:0] cb, input logic v, input logic n);
      logic [9:0] p;
      if (t) begin
         if (m_stk.size() == DEPTH) m_err = 1'b1;
         else m_stk.push_back({m_n, m_v, m_cb});
         {m_n, m_v, m_cb} = '0;
      end else if (r) begin
         if (m_stk.size() == 0) begin
            {m_n, m_v, m_cb} = '0;
            m_err = 1'b1;
         end else begin
            p = m_stk.pop_back();
            {m_n, m_v, m_cb} = p;
         end
      end else if (w) begin
         {m_n, m_v, m_cb} = md;
         if (md == '0) m_err = 1'b0;
      end else if (e) begin
         if (m_n) begin
            m_n = 1'b0;
            if (m_cnt < (1 << NCNT_W) - 1) m_cnt++;
         end else begin
            m_cb = cb; m_v = v; m_n = n;
         end
      end
   endtask

   always @(negedge clk) begin
      chk("cb_out", 32'(bus.cb_out), 32'(m_cb));
      chk("v_out", 32'(bus.v_out), 32'(m_v));
      chk("n_out", 32'(bus.n_out), 32'(m_n));
      chk("psw_out", 32'(bus.psw_out), 32'({m_n, m_v, m_cb}));
      chk("depth_out", 32'(bus.depth_out), 32'(m_stk.size()));
      chk("stk_err", 32'(bus.stk_err), 32'(m_err));
`ifdef PSW_NCOUNT_EN
      chk("ncount", 32'(bus.ncount), 32'(m_cnt));
`endif
   end

   task automatic idle();
      bus.psw_en = 1'b0; bus.cb_in = '0; bus.v_in = 1'b0; bus.n_in = 1'b0;
      bus.trap = 1'b0; bus.rfi = 1'b0; bus.mt_we = 1'b0; bus.mt_data = '0;
   endtask

   // Called at negedge+1; returns at the following negedge+1.
   task automatic cyc(input logic t, input logic r, input logic w, input logic e,
                      input logic [9:0] md, input logic [7:0] cb, input logic v, input logic n);
      bus.trap = t; bus.rfi = r; bus.mt_we = w; bus.psw_en = e;
      bus.mt_data = md; bus.cb_in = cb; bus.v_in = v; bus.n_in = n;
      @(posedge clk);
      model_step(t, r, w, e, md, cb, v, n);
      @(negedge clk);
      #1;
      idle();
      $display("txn t=%0b r=%0b w=%0b e=%0b md=%03h cb=%02h v=%0b n=%0b -> psw=%03h depth=%0d err=%0b",
               t, r, w, e, md, cb, v, n, bus.psw_out, bus.depth_out, bus.stk_err);
   endtask

   task automatic retire(input logic [7:0] cb, input logic v, input logic n);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 10'h000, cb, v, n);
   endtask
   task automatic mtw(input logic [9:0] d);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, d, 8'h00, 1'b0, 1'b0);
   endtask
   task automatic trp();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0);
   endtask
   task automatic rf();
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_psw", 32'(bus.psw_out), 32'h0);
      chk("rst_depth", 32'(bus.depth_out), 32'h0);
      chk("rst_err", 32'(bus.stk_err), 32'h0);
`ifdef PSW_NCOUNT_EN
      chk("rst_ncount", 32'(bus.ncount), 32'h0);
`endif
      model_reset();
      idle();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      $display("txn reset");
   endtask

   initial begin
      idle();
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("init_psw", 32'(bus.psw_out), 32'h0);
      chk("init_depth", 32'(bus.depth_out), 32'h0);
      rst_n = 1'b1;

      // Plain retire
      retire(8'hA5, 1'b1, 1'b0);
      chk("t1_cb", 32'(bus.cb_out), 32'hA5);
      chk("t1_psw", 32'(bus.psw_out), 32'h1A5);

      // Nullify-next, then a squashed retire
      retire(8'h0F, 1'b0, 1'b1);
      chk("t2a_cb", 32'(bus.cb_out), 32'h0F);
      chk("t2a_n", 32'(bus.n_out), 32'h1);
      retire(8'hFF, 1'b1, 1'b1);
      chk("t2b_cb", 32'(bus.cb_out), 32'h0F);
      chk("t2b_psw", 32'(bus.psw_out), 32'h00F);

      // Five nested traps into a 4-deep stack, then unwind
      for (int i = 0; i < 5; i++) begin
         mtw(10'(10'h101 + 10'h22 * i));
         chk("t3_load", 32'(bus.psw_out), 32'(10'h101 + 10'h22 * i));
         trp();
         chk("t3_clr", 32'(bus.psw_out), 32'h0);
      end
      chk("t3_depth", 32'(bus.depth_out), 32'd4);
      chk("t3_err", 32'(bus.stk_err), 32'h1);
      for (int k = 3; k >= 0; k--) begin
         rf();
         chk("t3_pop", 32'(bus.psw_out), 32'(10'h101 + 10'h22 * k));
      end
      chk("t3_empty", 32'(bus.depth_out), 32'd0);

      // Underflow and error clear
      mtw(10'h000);
      chk("t4_clr0", 32'(bus.stk_err), 32'h0);
      rf();
      chk("t4_psw", 32'(bus.psw_out), 32'h0);
      chk("t4_err", 32'(bus.stk_err), 32'h1);
      mtw(10'h000);
      chk("t4_clr1", 32'(bus.stk_err), 32'h0);

      // Everything at once: trap wins
      mtw(10'h2AB);
      trp();
      chk("t5_d1", 32'(bus.depth_out), 32'd1);
      mtw(10'h155);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 10'h3FF, 8'h77, 1'b1, 1'b1);
      chk("t5_d2", 32'(bus.depth_out), 32'd2);
      chk("t5_psw", 32'(bus.psw_out), 32'h0);
      rf();
      chk("t5_pop1", 32'(bus.psw_out), 32'h155);
      rf();
      chk("t5_pop2", 32'(bus.psw_out), 32'h2AB);

      // Nullify counter saturation, then asynchronous reset mid-sequence
      do_reset();
`ifdef PSW_NCOUNT_EN
      for (int i = 0; i < 4; i++) begin
         retire(8'h11, 1'b0, 1'b1);
         retire(8'h22, 1'b1, 1'b1);
         chk("t6_cb", 32'(bus.cb_out), 32'h11);
         chk("t6_ncount", 32'(bus.ncount), (i < 3) ? 32'(i + 1) : 32'd3);
      end
`endif
      mtw(10'h3C3);
      repeat (5) trp();
      retire(8'h3C, 1'b1, 1'b1);
      bus.trap = 1'b1; bus.psw_en = 1'b1;
      #2;
      do_reset();
      retire(8'h5A, 1'b0, 1'b0);
      chk("t6_after", 32'(bus.psw_out), 32'h05A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/psw_stack.md
Name: psw_stack

Overview:
Parametrised processor status word for the PA-RISC pipeline. It holds the per-digit carry/borrow vector, the overflow bit and the nullify bit. The nullify bit is applied to the next retiring instruction, so a nullified instruction cannot update status. The block also keeps a LIFO of saved PSWs for nested traps and returns-from-interrupt. It sits at the writeback stage, between the ALU/condition logic and the control-register file.

Parameters:
CB_W, 8, number of carry/borrow bits (one per 4-bit digit of a 32-bit datapath).
DEPTH, 4, number of saved-PSW entries in the trap stack (power of two, at least 2).
NCNT_W, 16, width of the nullified-instruction counter (optional feature only).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
psw_en  in  1  retire strobe; the instruction in writeback updates status
cb_in  in  CB_W  carry/borrow vector from the ALU
v_in  in  1  overflow from the ALU
n_in  in  1  nullify-next request from the condition logic
trap  in  1  push the current PSW onto the stack and clear the live PSW
rfi  in  1  pop the stack into the live PSW
mt_we  in  1  control-register write of the live PSW
mt_data  in  CB_W+2  packed write data {n,v,cb}
cb_out  out  CB_W  live carry/borrow vector
v_out  out  1  live overflow bit
n_out  out  1  live nullify bit (the next retiring instruction is squashed)
psw_out  out  CB_W+2  packed {n_out,v_out,cb_out}
depth_out  out  clog2(DEPTH)+1  number of occupied stack entries
stk_err  out  1  sticky flag: overflow or underflow occurred

Behaviour:
- Reset (rst_n=0, asynchronous): cb_out=0, v_out=0, n_out=0, depth_out=0, stk_err=0, all stack entries=0. Reset mid-operation aborts any push or pop; no partial state survives.
- All other updates are synchronous. Outputs are registered, so an input change is visible one cycle after the clock edge.
- Priority when several inputs are active in the same cycle: trap > rfi > mt_we > psw_en. Lower-priority requests in that cycle are dropped, not queued.
- psw_en with n_out=1: the retiring instruction is nullified.
  - n_out is set to 0.
  - cb_out and v_out hold; cb_in, v_in and n_in are ignored.
- psw_en with n_out=0:
  - cb_out is set to cb_in and v_out to v_in.
  - n_out is set to n_in.
  - A nullified instruction therefore cannot nullify its successor.
- mt_we: the live PSW is set to mt_data.
- trap, stack not full:
  - Entry[depth] is set to the live PSW, then depth increments.
  - The live PSW is cleared to 0.
- trap, stack full (depth=DEPTH):
  - Stack and depth hold; stk_err is set to 1.
  - The live PSW is still cleared, because trap entry always proceeds.
- rfi, depth>0: the live PSW is set to entry[depth-1], then depth decrements.
- rfi, depth=0: the live PSW is cleared to 0 and stk_err is set to 1.
- stk_err is sticky. It clears only on reset or on an mt_we write whose mt_data is all zeros.
- psw_out is always the concatenation of n_out, v_out and cb_out, with no additional latency.
- With no enables active, all state holds.

Optional Feature:
PSW_NCOUNT_EN:
- When defined, adds output ncount [NCNT_W-1:0].
  - Reset value 0.
  - Increments by 1 on every psw_en cycle that nullifies an instruction (psw_en=1, n_out=1, no higher-priority request active).
  - Saturates at all-ones; no wrap-around.
  - Unaffected by trap and rfi.
- When not defined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
1. Reset release, then psw_en with cb_in=8'hA5, v_in=1, n_in=0 -> next cycle cb_out=8'hA5, v_out=1, n_out=0, psw_out=10'h1A5.
2. psw_en with n_in=1 and cb_in=8'h0F, then psw_en with cb_in=8'hFF and n_in=1 -> after cycle 1: cb_out=8'h0F, n_out=1. After cycle 2: cb_out=8'h0F (held), n_out=0.
3. Load a distinct PSW, then trap, five times in a row with DEPTH=4 -> depth_out reaches 4, stk_err=1 after the fifth trap. Then four rfi pulses restore the 4th, 3rd, 2nd and 1st saved PSWs in that order, leaving depth_out=0.
4. rfi with an empty stack -> psw_out=0, stk_err=1. Then mt_we with mt_data=0 -> stk_err=0.
5. trap, rfi, mt_we and psw_en all high in the same cycle with depth=1 -> push occurs (depth_out=2), live PSW=0. The rfi, mt_we and psw_en requests are dropped.
6. PSW_NCOUNT_EN with NCNT_W=2: four nullified retires -> ncount goes 1, 2, 3, 3 (saturated). Asserting rst_n=0 mid-sequence -> ncount and all outputs return to 0 immediately.
